// File: rtl/opb_register_simulink2ppc_fifo_pkg.sv
// Shared constants for the Simulink-to-PPC FIFO register block: register
// offsets, status bit positions and the status word packing helper.
package s2p_pkg;

  // Word offsets within the register window
  localparam logic [1:0] S2P_OFF_DATA   = 2'd0;
  localparam logic [1:0] S2P_OFF_STATUS = 2'd1;
  localparam logic [1:0] S2P_OFF_CTRL   = 2'd2;

  // Status word bit positions
  localparam int S2P_ST_EMPTY      = 0;
  localparam int S2P_ST_FULL       = 1;
  localparam int S2P_ST_OVF        = 2;
  localparam int S2P_ST_CNT_LSB    = 4;
  localparam int S2P_ST_OVFCNT_LSB = 16;

  // Control word bit positions
  localparam int S2P_CTRL_FLUSH   = 0;
  localparam int S2P_CTRL_CLR_OVF = 1;

  // Assemble the status word from its fields
  function automatic logic [31:0] s2p_status(input logic       empty,
                                             input logic       full,
                                             input logic       ovf,
                                             input logic [3:0] count,
                                             input logic [15:0] ovf_cnt);
    logic [31:0] st;
    st = 32'h0000_0000;
    st[S2P_ST_EMPTY] = empty;
    st[S2P_ST_FULL]  = full;
    st[S2P_ST_OVF]   = ovf;
    st[S2P_ST_CNT_LSB +: 4]     = count;
    st[S2P_ST_OVFCNT_LSB +: 16] = ovf_cnt;
    return st;
  endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_fifo_if.sv
// OPB slave-side signal bundle. Buses keep the big-endian [0:n] numbering of
// the OPB, so bit 0 is the most significant bit.
interface opb_register_simulink2ppc_fifo_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_simulink2ppc_fifo_s2p_fifo.sv
// Circular word FIFO: storage, read/write pointers and exact occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge; flush empties the FIFO and discards any same-edge push or pop.
module s2p_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 32,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign pop_ok_s  = pop_i && !empty_o && !flush_i;
  assign push_ok_s = push_i && !flush_i && (!full_o || pop_ok_s);

  // Next pointers and occupancy; power-of-two depth gives modulo wrap
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written at the tail on an accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc_fifo.sv
// OPB register slave that hands words from user (Simulink) logic to the PPC
// through a FIFO. Offset 0 pops data, offset 1 is status, offset 2 controls
// flush / overflow clear. Optional feature macro: S2P_OVF_CNT_EN builds a
// saturating 16-bit dropped-word counter reported in status[31:16].
module opb_register_simulink2ppc_fifo
  import s2p_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0108_E000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108_E0FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5",
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic                            OPB_Clk,
  input  logic                            OPB_Rst_n,
  opb_register_simulink2ppc_fifo_if.slave opb,
  input  logic [31:0]                     user_data_in,
  input  logic                            user_data_valid,
  output logic                            user_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]              rst_sync_q;
  logic                    bus_en_s;
  logic [C_OPB_AWIDTH-1:0] addr_s;
  logic [C_OPB_DWIDTH-1:0] wdata_s;
  logic [1:0]              off_s;
  logic                    hit_s;

  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        pop_pend_q, pop_pend_d;
  logic        flush_pend_q, flush_pend_d;
  logic        clr_pend_q, clr_pend_d;

  logic          pop_s, flush_s, clr_s, ovf_evt_s;
  logic          ovf_q, ovf_d;
  logic [15:0]   ovf_cnt_s;
  logic [31:0]   head_s;
  logic          full_s, empty_s;
  logic [CW-1:0] count_s;
  logic [31:0]   status_s;

  // Release of reset is re-timed so the bus side wakes up two edges late
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign bus_en_s = rst_sync_q[1];

  // Address decode; the ack cycle itself never accepts a new hit
  assign addr_s  = opb.OPB_ABus;
  assign wdata_s = opb.OPB_DBus;
  assign off_s   = opb.OPB_ABus[28:29];
  assign hit_s   = opb.OPB_select && bus_en_s && !ack_q &&
                   (addr_s >= C_BASEADDR) && (addr_s <= C_HIGHADDR);

  assign status_s = s2p_status(empty_s, full_s, ovf_q, 4'(count_s), ovf_cnt_s);

  // Transfer decode: read data and deferred side effects are captured on the hit
  always_comb begin
    ack_d        = 1'b0;
    rdata_d      = 32'h0000_0000;
    pop_pend_d   = 1'b0;
    flush_pend_d = 1'b0;
    clr_pend_d   = 1'b0;
    if (hit_s) begin
      ack_d = 1'b1;
      if (opb.OPB_RNW) begin
        case (off_s)
          S2P_OFF_DATA: begin
            if (!empty_s) begin
              rdata_d    = head_s;
              pop_pend_d = 1'b1;
            end else begin
              rdata_d    = 32'h0000_0000;
              pop_pend_d = 1'b0;
            end
          end
          S2P_OFF_STATUS: rdata_d = status_s;
          default:        rdata_d = 32'h0000_0000;
        endcase
      end else if ((off_s == S2P_OFF_CTRL) && opb.OPB_BE[3]) begin
        flush_pend_d = wdata_s[S2P_CTRL_FLUSH];
        clr_pend_d   = wdata_s[S2P_CTRL_CLR_OVF];
      end else begin
        flush_pend_d = 1'b0;
        clr_pend_d   = 1'b0;
      end
    end else begin
      ack_d = 1'b0;
    end
  end

  // Bus response registers; reset abandons any transfer in flight
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ack_q        <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      pop_pend_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else begin
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      pop_pend_q   <= pop_pend_d;
      flush_pend_q <= flush_pend_d;
      clr_pend_q   <= clr_pend_d;
    end
  end

  // Side effects take place on the edge that ends the ack cycle
  assign pop_s     = ack_q && pop_pend_q;
  assign flush_s   = ack_q && flush_pend_q;
  assign clr_s     = ack_q && clr_pend_q;
  assign ovf_evt_s = user_data_valid && full_s && !pop_s && !flush_s;

  // Sticky overflow flag next state
  always_comb begin
    ovf_d = ovf_q;
    if (clr_s) begin
      ovf_d = 1'b0;
    end else if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sticky overflow flag
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

`ifdef S2P_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Dropped-word counter next state, saturating at all ones
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr_s) begin
      ovf_cnt_d = 16'h0000;
    end else if (ovf_evt_s && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'h0001;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Dropped-word counter
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ovf_cnt_q <= 16'h0000;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt_s = ovf_cnt_q;
`else
  assign ovf_cnt_s = 16'h0000;
`endif

  s2p_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk     (OPB_Clk),
    .rst_n   (OPB_Rst_n),
    .push_i  (user_data_valid),
    .data_i  (user_data_in),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .data_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  assign user_ready     = !full_s;
  assign opb.Sl_DBus    = rdata_q;
  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc_fifo.sv
// Self-checking bench for opb_register_simulink2ppc_fifo. A queue-based model
// tracks FIFO contents, the sticky overflow flag and the dropped-word count.
module tb_opb_register_simulink2ppc_fifo;

  localparam int          D    = 8;
  localparam logic [31:0] BASE = 32'h0108_E000;
  localparam logic [31:0] HIGH = 32'h0108_E0FF;

  logic        clk;
  logic        rst_n;
  logic [31:0] user_data_in;
  logic        user_data_valid;
  logic        user_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mq[$];
  bit          m_ovf;
  int          m_cnt;

  opb_register_simulink2ppc_fifo_if bus ();

  opb_register_simulink2ppc_fifo dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .opb             (bus),
    .user_data_in    (user_data_in),
    .user_data_valid (user_data_valid),
    .user_ready      (user_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_status();
    logic [15:0] c;
    int n;
    c = 16'h0000;
`ifdef S2P_OVF_CNT_EN
    c = (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
`endif
    n = mq.size();
    return {c, 8'h00, 4'(n), 1'b0, m_ovf, (n == D), (n == 0)};
  endfunction

  // Model of a user push; call after any same-edge pop has been applied
  function automatic void model_push(input logic [31:0] d);
    if (mq.size() < D) mq.push_back(d);
    else begin
      m_ovf = 1'b1;
      m_cnt++;
    end
  endfunction

  function automatic logic [31:0] model_pop();
    if (mq.size() == 0) return 32'h0;
    return mq.pop_front();
  endfunction

  task automatic push_word(input logic [31:0] d);
    @(negedge clk);
    user_data_valid = 1'b1;
    user_data_in    = d;
    @(negedge clk);
    user_data_valid = 1'b0;
    model_push(d);
  endtask

  // One OPB transfer; select is dropped in the cycle after it is first sampled.
  // Optionally pushes a user word during that (ack) cycle.
  task automatic opb_xfer(input logic [31:0] addr, input bit rnw, input logic [31:0] wd,
                          input bit push_en, input logic [31:0] pd,
                          output bit ack1, output bit ack2, output logic [31:0] rd);
    @(negedge clk);
    bus.OPB_ABus   = addr;
    bus.OPB_RNW    = rnw;
    bus.OPB_DBus   = wd;
    bus.OPB_BE     = 4'hF;
    bus.OPB_select = 1'b1;
    @(posedge clk); #1;
    ack1 = bus.Sl_xferAck;
    rd   = bus.Sl_DBus;
    @(negedge clk);
    bus.OPB_select = 1'b0;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_DBus   = 32'h0;
    if (push_en) begin
      user_data_valid = 1'b1;
      user_data_in    = pd;
    end
    @(posedge clk); #1;
    ack2 = bus.Sl_xferAck;
    @(negedge clk);
    user_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit a1, a2; logic [31:0] rd;
    rst_n = 1'b0;
    user_data_valid = 1'b0; user_data_in = 32'h0;
    bus.OPB_ABus = 32'h0; bus.OPB_BE = 4'h0; bus.OPB_DBus = 32'h0;
    bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.Sl_xferAck !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.Sl_xferAck); end
    checks++; if (bus.Sl_DBus !== 32'h0) begin failures++; $display("FAIL reset_dbus got=%h exp=0", bus.Sl_DBus); end
    checks++; if (user_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", user_ready); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    opb_xfer(BASE + 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (a1 !== 1'b1 || rd !== 32'h0000_0001) begin failures++; $display("FAIL reset_status ack=%b got=%h exp=00000001", a1, rd); end
  endtask

  task automatic test_order();
    bit a1, a2; logic [31:0] rd, ex;
    push_word(32'h1111_1111);
    push_word(32'h2222_2222);
    push_word(32'h3333_3333);
    for (int i = 0; i < 4; i++) begin
      ex = model_pop();
      opb_xfer(BASE, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
      checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin failures++; $display("FAIL order_ack%0d got=%b%b exp=10", i, a1, a2); end
      checks++; if (rd !== ex) begin failures++; $display("FAIL order_data%0d got=%h exp=%h", i, rd, ex); end
    end
    opb_xfer(BASE + 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (rd[0] !== 1'b1 || rd !== exp_status()) begin failures++; $display("FAIL order_empty got=%h exp=%h", rd, exp_status()); end
  endtask

  task automatic test_overflow();
    bit a1, a2; logic [31:0] rd;
    for (int i = 0; i < 8; i++) push_word($urandom);
    checks++; if (user_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready got=%b exp=0", user_ready); end
    push_word(32'hDEAD_BEEF);
    opb_xfer(BASE + 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
`ifdef S2P_OVF_CNT_EN
    checks++; if (rd !== 32'h0001_0086) begin failures++; $display("FAIL ovf_status got=%h exp=00010086", rd); end
`else
    checks++; if (rd !== 32'h0000_0086) begin failures++; $display("FAIL ovf_status got=%h exp=00000086", rd); end
`endif
    checks++; if (rd !== exp_status()) begin failures++; $display("FAIL ovf_model got=%h exp=%h", rd, exp_status()); end
  endtask

  task automatic test_ctrl();
    bit a1, a2; logic [31:0] rd, ex;
    for (int i = 0; i < 3; i++) begin
      ex = model_pop();
      opb_xfer(BASE, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
      checks++; if (rd !== ex) begin failures++; $display("FAIL ctrl_pre_data got=%h exp=%h", rd, ex); end
    end
    opb_xfer(BASE + 32'h8, 1'b0, 32'h0000_0003, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (a1 !== 1'b1) begin failures++; $display("FAIL ctrl_ack got=%b exp=1", a1); end
    mq.delete(); m_ovf = 1'b0; m_cnt = 0;
    opb_xfer(BASE + 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (rd !== 32'h0000_0001) begin failures++; $display("FAIL ctrl_status got=%h exp=00000001", rd); end
    opb_xfer(BASE + 32'h8, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (a1 !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL ctrl_read ack=%b got=%h exp=0", a1, rd); end
  endtask

  task automatic test_simul();
    bit a1, a2; logic [31:0] rd, ex;
    for (int i = 0; i < 8; i++) push_word(32'h5000_0000 + 32'(i));
    ex = model_pop();
    model_push(32'hAAAA_5555);
    opb_xfer(BASE, 1'b1, 32'h0, 1'b1, 32'hAAAA_5555, a1, a2, rd);
    checks++; if (rd !== ex) begin failures++; $display("FAIL simul_data got=%h exp=%h", rd, ex); end
    opb_xfer(BASE + 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (rd !== 32'h0000_0082) begin failures++; $display("FAIL simul_status got=%h exp=00000082", rd); end
    for (int i = 0; i < 8; i++) begin
      ex = model_pop();
      opb_xfer(BASE, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
      checks++; if (rd !== ex) begin failures++; $display("FAIL simul_drain%0d got=%h exp=%h", i, rd, ex); end
    end
    checks++; if (ex !== 32'hAAAA_5555) begin failures++; $display("FAIL simul_last got=%h exp=aaaa5555", ex); end
  endtask

  task automatic test_back_to_back();
    bit a1, a2; logic [31:0] rd, ex;
    push_word(32'hCAFE_0001);
    push_word(32'hCAFE_0002);
    ex = model_pop();
    @(negedge clk);
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.Sl_xferAck !== 1'b1 || bus.Sl_DBus !== ex) begin failures++; $display("FAIL b2b_first ack=%b got=%h exp=%h", bus.Sl_xferAck, bus.Sl_DBus, ex); end
    @(posedge clk); #1;
    checks++; if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) begin failures++; $display("FAIL b2b_double ack=%b dbus=%h exp=0", bus.Sl_xferAck, bus.Sl_DBus); end
    @(negedge clk); bus.OPB_select = 1'b0;
    opb_xfer(BASE + 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (rd !== exp_status()) begin failures++; $display("FAIL b2b_status got=%h exp=%h", rd, exp_status()); end
  endtask

  task automatic test_addr_range();
    bit a1, a2; logic [31:0] rd;
    opb_xfer(HIGH + 32'h1, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (a1 !== 1'b0 || a2 !== 1'b0) begin failures++; $display("FAIL range_out ack=%b%b exp=00", a1, a2); end
    opb_xfer(HIGH - 32'h3, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (a1 !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL range_high ack=%b got=%h exp=0", a1, rd); end
    opb_xfer(BASE, 1'b0, $urandom, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (a1 !== 1'b1) begin failures++; $display("FAIL range_wr0 ack=%b exp=1", a1); end
    opb_xfer(BASE + 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (rd !== exp_status()) begin failures++; $display("FAIL range_status got=%h exp=%h", rd, exp_status()); end
  endtask

  task automatic test_random();
    bit a1, a2; logic [31:0] rd, ex, d, w;
    int op; bit pe;
    for (int it = 0; it < 120; it++) begin
      checks++; if (user_ready !== (mq.size() < D)) begin failures++; $display("FAIL rnd_ready%0d got=%b exp=%b", it, user_ready, (mq.size() < D)); end
      op = $urandom_range(0, 9);
      d  = $urandom;
      if (op <= 3) push_word(d);
      else if (op <= 6) begin
        pe = $urandom_range(0, 1);
        ex = model_pop();
        if (pe) model_push(d);
        opb_xfer(BASE, 1'b1, 32'h0, pe, d, a1, a2, rd);
        checks++; if (a1 !== 1'b1 || a2 !== 1'b0 || rd !== ex) begin failures++; $display("FAIL rnd_data%0d ack=%b%b got=%h exp=%h", it, a1, a2, rd, ex); end
      end else if (op <= 8) begin
        ex = exp_status();
        opb_xfer(BASE + 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
        checks++; if (rd !== ex) begin failures++; $display("FAIL rnd_status%0d got=%h exp=%h", it, rd, ex); end
      end else begin
        w = {30'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
        opb_xfer(BASE + 32'h8, 1'b0, w, 1'b0, 32'h0, a1, a2, rd);
        if (w[0]) mq.delete();
        if (w[1]) begin m_ovf = 1'b0; m_cnt = 0; end
      end
    end
  endtask

  task automatic test_reset_abort();
    bit a1, a2; logic [31:0] rd;
    push_word(32'h7777_0001);
    push_word(32'h7777_0002);
    @(negedge clk);
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (user_ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", user_ready); end
    @(posedge clk); #1;
    checks++; if (bus.Sl_xferAck !== 1'b0 || bus.Sl_DBus !== 32'h0) begin failures++; $display("FAIL abort_ack ack=%b dbus=%h exp=0", bus.Sl_xferAck, bus.Sl_DBus); end
    @(negedge clk);
    bus.OPB_select = 1'b0;
    rst_n = 1'b1;
    mq.delete(); m_ovf = 1'b0; m_cnt = 0;
    repeat (2) @(negedge clk);
    opb_xfer(BASE + 32'h4, 1'b1, 32'h0, 1'b0, 32'h0, a1, a2, rd);
    checks++; if (rd !== 32'h0000_0001) begin failures++; $display("FAIL abort_status got=%h exp=00000001", rd); end
  endtask

  initial begin
    test_reset();
    test_order();
    test_overflow();
    test_ctrl();
    test_simul();
    test_back_to_back();
    test_addr_range();
    test_random();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
